// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU for ADD/SUB/logic/SHL, plus a multi-cycle
// shift-add unsigned multiplier (WIDTH steps, LSB of multiplier first).
// Flags and result are registered and hold until the next completion.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc;       // product accumulator, double width
    logic [2*WIDTH-1:0]   mcand;     // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier;    // multiplier, shifted right each step
    logic [2:0]           op_q;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 last;
    logic                 stepping;

    assign busy     = (state == MUL);
    assign stepping = (state == MUL) && (op_q == OP_MUL);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign acc_step = acc + (mplier[0] ? mcand : '0);

    // single-cycle operations, evaluated straight from the input operands
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD:  {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {alu_c, alu_res} = {1'b0, a} - {1'b0, b};  // top bit is the borrow
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_SHL: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[WIDTH-1];
            end
            default: ;  // MUL is handled by the sequencer
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: only a MUL request leaves IDLE; MUL ends after the last step
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && op == OP_MUL) state_nxt = MUL;
            MUL:     if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // operand latch, multiply steps and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            op_q   <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        op_q   <= op;
                        acc    <= '0;
                        cnt    <= '0;
                        if (op != OP_MUL) begin
                            result <= alu_res;
                            carry  <= alu_c;
                            zero   <= (alu_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // start is deliberately not looked at here
                    if (stepping) begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            result <= acc_step[WIDTH-1:0];
                            carry  <= |acc_step[2*WIDTH-1:WIDTH];
                            zero   <= (acc_step[WIDTH-1:0] == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 with hand-computed expectations.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         start;
    logic         busy, done, carry, zero;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .start(start),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one-cycle start pulse with the given operation
    task automatic go(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic [W-1:0] r, input logic c, input logic z);
        chk({tag, ".done"},   done,   1);
        chk({tag, ".busy"},   busy,   0);
        chk({tag, ".result"}, result, r);
        chk({tag, ".carry"},  carry,  c);
        chk({tag, ".zero"},   zero,   z);
    endtask

    // MUL with exact-latency checks; optionally pokes start mid-run
    task automatic run_mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] r, input logic c, input logic z, input bit poke);
        go(3'b111, x, y);
        chk({tag, ".busy0"}, busy, 1);
        chk({tag, ".done0"}, done, 0);
        a = 16'h1234; b = 16'h5678; op = 3'b010;   // operand changes must not matter
        for (int i = 1; i < W; i++) begin
            if (poke && i == 5) begin op = 3'b000; a = 16'h0001; b = 16'h0001; start = 1'b1; end
            tick();
            start = 1'b0;
            chk({tag, ".busy_run"}, busy, 1);
            chk({tag, ".done_run"}, done, 0);
        end
        tick();
        chk_done(tag, r, c, z);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
        #3;
        chk("rst.result", result, 0);
        chk("rst.carry",  carry,  0);
        chk("rst.zero",   zero,   0);
        chk("rst.done",   done,   0);
        chk("rst.busy",   busy,   0);
        tick();
        rst_n = 1'b1;

        // first edge after release accepts start
        go(3'b000, 16'hFFFF, 16'h0001);
        chk_done("add_wrap", 16'h0000, 1, 1);
        tick();
        chk("add_wrap.done_pulse", done, 0);
        chk("add_wrap.hold", result, 16'h0000);

        go(3'b001, 16'h0003, 16'h0005); chk_done("sub_borrow", 16'hFFFE, 1, 0);
        go(3'b010, 16'hF0F0, 16'h0FF0); chk_done("and", 16'h00F0, 0, 0);
        go(3'b110, 16'h8001, 16'h0000); chk_done("shl", 16'h0002, 1, 0);
        go(3'b011, 16'h1200, 16'h0034); chk_done("or", 16'h1234, 0, 0);
        go(3'b100, 16'hAAAA, 16'hAAAA); chk_done("xor", 16'h0000, 0, 1);
        go(3'b101, 16'h0000, 16'hFFFF); chk_done("not", 16'hFFFF, 0, 0);
        go(3'b000, 16'h7000, 16'h1000); chk_done("add_nc", 16'h8000, 0, 0);

        // MUL with an ignored start mid-run; result held until then
        run_mul("mul_ff3", 16'h00FF, 16'h0003, 16'h02FD, 0, 0, 1'b1);
        tick();
        chk("mul_ff3.single_done", done, 0);
        chk("mul_ff3.hold", result, 16'h02FD);

        run_mul("mul_ovf", 16'hFFFF, 16'hFFFF, 16'h0001, 1, 0, 1'b0);
        run_mul("mul_zero", 16'h0100, 16'h0100, 16'h0000, 1, 1, 1'b0);

        // reset mid-MUL after 7 steps: async clear, no done
        go(3'b111, 16'hFFFF, 16'hFFFF);
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.result", result, 0);
        chk("arst.carry",  carry,  0);
        chk("arst.zero",   zero,   0);
        chk("arst.busy",   busy,   0);
        chk("arst.done",   done,   0);
        tick();
        tick();
        chk("arst.no_done", done, 0);
        rst_n = 1'b1;
        go(3'b000, 16'h0002, 16'h0003); chk_done("add_after_rst", 16'h0005, 0, 0);

        // back-to-back: ADD right after done, then MUL right after that
        go(3'b000, 16'h0007, 16'h0008); chk_done("b2b_add", 16'h000F, 0, 0);
        run_mul("b2b_mul", 16'h0012, 16'h0034, 16'h03A8, 0, 0, 1'b0);
        go(3'b000, 16'h0001, 16'h0001); chk_done("b2b_add2", 16'h0002, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
